// File: rtl/econet_pkg.sv
// econet_pkg: shared state encoding, register layout and backoff helpers for the Econet transmit arbiter
package econet_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINE = 3'd1,
    ST_GRANTED   = 3'd2,
    ST_BACKOFF   = 3'd3,
    ST_FAIL      = 3'd4
  } arb_state_e;
  localparam int THR_LSB       = 0;
  localparam int MAX_RETRY_LSB = 8;
  localparam int RETRY_CNT_LSB = 12;
  localparam int IRQ_EN_BIT    = 16;
  localparam int LINE_IDLE_BIT = 17;
  localparam int STATE_LSB     = 18;
  localparam int FAIL_BIT      = 24;
  localparam int COLL_BIT      = 25;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Exponential window: 2^min(r,8) - 1, so the window stops growing at 8 retries
  function automatic logic [7:0] backoff_mask(input logic [3:0] r);
    logic [8:0] m;
    m = (9'd1 << (r > 4'd8 ? 4'd8 : r)) - 9'd1;
    return m[7:0];
  endfunction
endpackage

// File: rtl/econet_backoff_lfsr.sv
// econet_backoff_lfsr: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) feeding the random backoff
module econet_backoff_lfsr
  import econet_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);
  // Shift every clk; the seed is non-zero so the all-zero lockup state is never reached
  always_ff @(posedge clk)
    q <= reset ? LFSR_SEED : {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/econet_tx_arbiter.sv
// econet_tx_arbiter: Econet line-access arbiter with idle detection and exponential backoff (random backoff with ECONET_BACKOFF_RANDOM_EN)
module econet_tx_arbiter
  import econet_pkg::*;
#(
  parameter logic [7:0] IDLE_DEF  = 8'd15,
  parameter logic [3:0] RETRY_DEF = 4'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  wr,
  input  logic        select,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        econet_tick,
  input  logic        line_rx,
  input  logic        collision_detect,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_grant,
  output logic        tx_abort,
  output logic        irq
);
  arb_state_e state, state_nx;
  logic [7:0] idle_thr, idle_cnt, thr_eff, mask;
  logic [3:0] max_retry, retry_cnt, retry_inc;
  logic [8:0] bo_cnt, bo_load;
  logic       irq_en, fail, coll_seen, line_idle, coll_hit, bo_done, w1c, unused_data;
  assign thr_eff     = idle_thr == 8'd0 ? 8'd1 : idle_thr;
  assign line_idle   = idle_cnt >= thr_eff;
  assign retry_inc   = retry_cnt == 4'hF ? 4'hF : retry_cnt + 4'd1;
  assign mask        = backoff_mask(retry_inc);
  assign coll_hit    = state == ST_GRANTED && !tx_done && collision_detect;
  assign bo_done     = state == ST_BACKOFF && econet_tick && bo_cnt == 9'd1;
  assign w1c         = select && wr[3];
  assign irq         = fail & irq_en;
  assign unused_data = ^{data_in[31:26], data_in[23:17], data_in[15:12]};
`ifdef ECONET_BACKOFF_RANDOM_EN
  logic [7:0] lfsr;
  econet_backoff_lfsr u_lfsr (.clk(clk), .reset(reset), .q(lfsr));
  assign bo_load = {1'b0, lfsr & mask} + 9'd1;
`else
  assign bo_load = {1'b0, mask} + 9'd1;
`endif
  // Next-state decode; tx_done outranks a simultaneous collision
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      state_nx = tx_req ? ST_WAIT_LINE : ST_IDLE;
      ST_WAIT_LINE: state_nx = !tx_req ? ST_IDLE : line_idle ? ST_GRANTED : ST_WAIT_LINE;
      ST_GRANTED:   state_nx = tx_done ? ST_IDLE
                             : collision_detect ? (retry_inc > max_retry ? ST_FAIL : ST_BACKOFF)
                             : !tx_req ? ST_IDLE : ST_GRANTED;
      ST_BACKOFF:   state_nx = bo_done ? ST_WAIT_LINE : ST_BACKOFF;
      ST_FAIL:      state_nx = tx_req ? ST_FAIL : ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end
  // State register and registered transmitter handshake
  always_ff @(posedge clk)
    if (reset) begin
      state    <= ST_IDLE;
      tx_grant <= 1'b0;
      tx_abort <= 1'b0;
    end else begin
      state    <= state_nx;
      tx_grant <= state_nx == ST_GRANTED;
      tx_abort <= coll_hit;
    end
  // Retry tally, backoff countdown and bus-idle run length
  always_ff @(posedge clk)
    if (reset) begin
      retry_cnt <= '0;
      bo_cnt    <= '0;
      idle_cnt  <= '0;
    end else begin
      retry_cnt <= coll_hit ? retry_inc
                 : (state == ST_GRANTED || state == ST_FAIL) && state_nx == ST_IDLE ? 4'd0 : retry_cnt;
      bo_cnt    <= coll_hit ? bo_load : state == ST_BACKOFF && econet_tick ? bo_cnt - 9'd1 : bo_cnt;
      idle_cnt  <= collision_detect || bo_done || (econet_tick && !line_rx) ? 8'd0
                 : econet_tick && idle_cnt != 8'hFF ? idle_cnt + 8'd1 : idle_cnt;
    end
  // CPU-visible configuration and sticky status; a hardware set beats a same-cycle clear
  always_ff @(posedge clk)
    if (reset) begin
      idle_thr  <= IDLE_DEF;
      max_retry <= RETRY_DEF;
      irq_en    <= 1'b0;
      fail      <= 1'b0;
      coll_seen <= 1'b0;
    end else begin
      idle_thr  <= select && wr[0] ? data_in[THR_LSB +: 8] : idle_thr;
      max_retry <= select && wr[1] ? data_in[MAX_RETRY_LSB +: 4] : max_retry;
      irq_en    <= select && wr[2] ? data_in[IRQ_EN_BIT] : irq_en;
      fail      <= state_nx == ST_FAIL || (fail && !(w1c && data_in[FAIL_BIT]));
      coll_seen <= coll_hit || (coll_seen && !(w1c && data_in[COLL_BIT]));
    end
  // Register read view
  always_comb begin
    data_out = '0;
    data_out[THR_LSB +: 8]       = idle_thr;
    data_out[MAX_RETRY_LSB +: 4] = max_retry;
    data_out[RETRY_CNT_LSB +: 4] = retry_cnt;
    data_out[IRQ_EN_BIT]         = irq_en;
    data_out[LINE_IDLE_BIT]      = line_idle;
    data_out[STATE_LSB +: 3]     = state;
    data_out[FAIL_BIT]           = fail;
    data_out[COLL_BIT]           = coll_seen;
  end
endmodule

// File: tb/tb_econet_tx_arbiter.sv
// tb_econet_tx_arbiter: randomized scoreboard bench for the Econet transmit arbiter
module tb_econet_tx_arbiter;
  logic        clk = 1'b0, reset = 1'b1, select = 1'b0;
  logic [3:0]  wr = '0;
  logic [31:0] data_in = '0, data_out;
  logic        econet_tick = 1'b0, line_rx = 1'b1, collision_detect = 1'b0, tx_req = 1'b0, tx_done = 1'b0;
  logic        tx_grant, tx_abort, irq;

  econet_tx_arbiter dut (
    .clk(clk), .reset(reset), .wr(wr), .select(select), .data_in(data_in), .data_out(data_out),
    .econet_tick(econet_tick), .line_rx(line_rx), .collision_detect(collision_detect),
    .tx_req(tx_req), .tx_done(tx_done), .tx_grant(tx_grant), .tx_abort(tx_abort), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [34:0] val; string name;} snap_t;
  typedef struct {int cyc; bit abort;} ev_t;
  snap_t snap_q[$];
  ev_t   ev_q[$];
  int cyc = 0, checks = 0, errors = 0;
  // Reference view of the block: register contents, architectural state, grant level
  int thr = 15, maxr = 8, retry = 0, st = 0, run = 0;
  bit ien = 0, mfail = 0, mcoll = 0, grant_m = 0;
  localparam logic [34:0] SNAP_MASK = ~(35'd1 << 17);

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scheduled snapshots plus every grant rise / abort pulse against the event queue
  snap_t s;
  ev_t e;
  logic [34:0] act;
  logic grant_q = 1'b0;
  always @(negedge clk) begin
    act = {irq, tx_abort, tx_grant, data_out};
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      s = snap_q.pop_front();
      checks++;
      if (s.cyc != cyc || (act & SNAP_MASK) !== (s.val & SNAP_MASK)) begin
        errors++;
        $display("FAIL %s cyc %0d: got %h want %h (due %0d)", s.name, cyc, act & SNAP_MASK, s.val & SNAP_MASK, s.cyc);
      end
    end
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      e = ev_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event abort=%0d due cyc %0d, overdue at cyc %0d", e.abort, e.cyc, cyc);
    end
    if ((tx_grant === 1'b1 && grant_q !== 1'b1) || tx_abort === 1'b1) begin
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event grant=%0b abort=%0b at cyc %0d, want none", tx_grant, tx_abort, cyc);
      end else begin
        e = ev_q.pop_front();
        if (e.cyc != cyc || e.abort != tx_abort) begin
          errors++;
          $display("FAIL event_timing got abort=%0b at cyc %0d, want abort=%0b at cyc %0d", tx_abort, cyc, e.abort, e.cyc);
        end
      end
    end
    grant_q = tx_grant;
  end

  function automatic logic [34:0] exp_word(int sv, bit g, bit a);
    logic [31:0] d;
    d = '0;
    d[7:0]   = thr[7:0];
    d[11:8]  = maxr[3:0];
    d[15:12] = retry[3:0];
    d[16]    = ien;
    d[20:18] = sv[2:0];
    d[24]    = mfail;
    d[25]    = mcoll;
    return {mfail & ien, a, g, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(string n, int sv, bit g, bit a);
    snap_q.push_back('{cyc: cyc + 1, val: exp_word(sv, g, a), name: n});
  endtask

  task automatic wreg(logic [3:0] m, logic [31:0] d);
    select = 1'b1; wr = m; data_in = d;
    if (m[0]) thr = int'(d[7:0]);
    if (m[1]) maxr = int'(d[11:8]);
    if (m[2]) ien = d[16];
    if (m[3] && d[24] && !(st == 4 && tx_req)) mfail = 0;
    if (m[3] && d[25]) mcoll = 0;
    expect_next("reg_write", st, grant_m, 0);
    step();
    select = 1'b0; wr = '0;
  endtask

  // Feed random clean/busy bit times until the run of clean ticks reaches the threshold
  task automatic drive_until_grant();
    bit l;
    int te;
    te = thr == 0 ? 1 : thr;
    for (int i = 0; i < 200; i++) begin
      l = i > 150 || $urandom_range(0, 3) != 0;
      run = l ? run + 1 : 0;
      econet_tick = 1'b1; line_rx = l;
      if (run >= te) begin
        ev_q.push_back('{cyc: cyc + 2, abort: 1'b0});
        step(); econet_tick = 1'b0; line_rx = 1'b1;
        step();
        st = 2; grant_m = 1;
        expect_next("granted", 2, 1, 0);
        step();
        return;
      end
      step(); econet_tick = 1'b0; line_rx = 1'b1;
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  // Backoff ticks with the line busy so the arbiter cannot grant early
  task automatic backoff();
    int l;
    l = retry >= 8 ? 256 : (1 << retry);
    for (int i = 1; i <= l; i++) begin
      econet_tick = 1'b1; line_rx = 1'b0;
      if (i == l) begin
        st = 1;
        expect_next("backoff_end", 1, 0, 0);
      end
`ifndef ECONET_BACKOFF_RANDOM_EN
      else if (i == l - 1) expect_next("backoff_hold", 3, 0, 0);
`endif
      step(); econet_tick = 1'b0; line_rx = 1'b1;
      if ($urandom_range(0, 1) == 1) step();
    end
    run = 0;
  endtask

  // One frame attempt; mode -1 random outcome, 0 done, 1 drop request, 2 collide until fail (or 17 times)
  task automatic trial(int t, int m, bit ie, int mode);
    int colls, o;
    bit fin;
    colls = 0; fin = 0;
    wreg(4'b0111, 32'(t) | (32'(m) << 8) | (32'(ie) << 16));
    wreg(4'b1000, 32'h0300_0000);
    econet_tick = 1'b1; line_rx = 1'b0; step(); econet_tick = 1'b0; line_rx = 1'b1; run = 0;
    tx_req = 1'b1; st = 1;
    expect_next("req_wait", 1, 0, 0);
    step();
    while (!fin) begin
      drive_until_grant();
      o = mode >= 0 ? mode : $urandom_range(0, 4);
      if (mode == 2 && colls >= 17) o = 0;
      if (o == 0) begin
        tx_done = 1'b1; tx_req = 1'b0; collision_detect = 1'($urandom_range(0, 1));
        st = 0; grant_m = 0; retry = 0;
        expect_next("done", 0, 0, 0);
        step(); tx_done = 1'b0; collision_detect = 1'b0; fin = 1;
      end else if (o == 1) begin
        tx_req = 1'b0; st = 0; grant_m = 0; retry = 0;
        expect_next("drop_req", 0, 0, 0);
        step(); fin = 1;
      end else begin
        colls++;
        collision_detect = 1'b1;
        retry = retry < 15 ? retry + 1 : 15;
        mcoll = 1; grant_m = 0;
        ev_q.push_back('{cyc: cyc + 1, abort: 1'b1});
        if (retry > maxr) begin
          st = 4; mfail = 1;
          expect_next("coll_fail", 4, 0, 1);
          step(); collision_detect = 1'b0;
          wreg(4'b1000, 32'h0100_0000);
          tx_req = 1'b0; st = 0; retry = 0;
          expect_next("fail_exit", 0, 0, 0);
          step();
          wreg(4'b1000, 32'h0300_0000);
          fin = 1;
        end else begin
          st = 3;
          expect_next("coll_backoff", 3, 0, 1);
          step(); collision_detect = 1'b0;
          backoff();
        end
      end
    end
  endtask

  initial begin
    step(); step();
    expect_next("reset", 0, 0, 0);
    step(); reset = 1'b0;
    trial(4, 8, 0, 0);
    trial(4, 2, 1, 2);
    trial(0, 0, 1, 2);
    trial(3, 3, 1, 1);
    repeat (25) trial($urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    trial(1, 15, 0, 2);
    wreg(4'b0111, 32'h0001_0302);
    econet_tick = 1'b1; line_rx = 1'b0; step(); econet_tick = 1'b0; line_rx = 1'b1; run = 0;
    tx_req = 1'b1; st = 1;
    expect_next("req_wait", 1, 0, 0);
    step();
    drive_until_grant();
    reset = 1'b1; collision_detect = 1'b1; tx_req = 1'b0;
    thr = 15; maxr = 8; ien = 0; retry = 0; st = 0; mfail = 0; mcoll = 0; grant_m = 0;
    expect_next("reset_in_grant", 0, 0, 0);
    step(); reset = 1'b0; collision_detect = 1'b0;
    repeat (4) step();
    checks++;
    if (snap_q.size() != 0 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending snaps %0d events %0d, want 0 0", snap_q.size(), ev_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/econet_tx_arbiter.md
# econet_tx_arbiter

Line-access controller for the Econet transmitter. It takes a transmit request from the frame transmitter and waits for the bus to be idle for a programmable number of Econet bit times before granting the line. On a collision it aborts the transmission and applies binary exponential backoff, retrying up to a programmable limit. It sits on the CPU register bus next to the Econet hardware-control block and consumes that block's collision-detect and bit-clock signals.

## Interface
Parameters:
- IDLE_DEF, 8'd15: reset value of the idle threshold, in bit times.
- RETRY_DEF, 4'd8: reset value of the retry limit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- wr  in  4  byte write strobes.
- select  in  1  register select.
- data_in  in  32  write data.
- data_out  out  32  read data.
- econet_tick  in  1  one-clk pulse per Econet bit clock.
- line_rx  in  1  received line level, already synchronised; 1 means mark.
- collision_detect  in  1  collision indication, already synchronised.
- tx_req  in  1  level; the transmitter has a frame to send.
- tx_done  in  1  one-clk pulse; the frame completed.
- tx_grant  out  1  line granted to the transmitter.
- tx_abort  out  1  one-clk pulse; the transmitter must abandon the frame.
- irq  out  1  fail interrupt.

## Operation
Register word (a write takes effect only when both select and the wr byte strobe are set):
- [7:0] idle_thr, RW, reset IDLE_DEF. A value of 0 is treated as 1.
- [11:8] max_retry, RW, reset RETRY_DEF.
- [15:12] retry_cnt, RO.
- [16] irq_en, RW, reset 0.
- [17] line_idle, RO.
- [20:18] state, RO.
- [24] fail, W1C via wr[3].
- [25] coll_seen, W1C via wr[3].
- All other bits read 0.

Idle counter (8-bit, saturating):
- On each econet_tick with line_rx=1 and collision_detect=0, the counter increments.
- On any tick with line_rx=0, or on any clk with collision_detect=1, the counter clears.
- line_idle = (count >= idle_thr).

State machine (state encoding in brackets):
- IDLE(0): when tx_req=1, go to WAIT_LINE.
- WAIT_LINE(1):
  - If tx_req=0, go to IDLE.
  - If line_idle=1, go to GRANTED.
- GRANTED(2): tx_grant=1.
  - If tx_done=1: go to IDLE and clear retry_cnt.
  - Else if collision_detect=1: pulse tx_abort, set coll_seen, increment retry_cnt.
    - If the new retry_cnt > max_retry, go to FAIL.
    - Otherwise go to BACKOFF.
  - Else if tx_req=0: go to IDLE with no abort, and clear retry_cnt.
- BACKOFF(3): the backoff counter decrements on each econet_tick. When it reaches 0, clear the idle counter and go to WAIT_LINE.
- FAIL(4): set fail. Stay in FAIL until tx_req=0, then go to IDLE and clear retry_cnt.

Backoff load value:
- mask = 2^min(retry_cnt,8) − 1, 8 bits wide.
- load = (lfsr & mask) + 1, 9 bits wide, so the backoff is 1..256 ticks.

LFSR:
- 8-bit Fibonacci, taps 8,6,5,4.
- Advances every clk. Reset value 8'hA5; it never reaches 0.

Outputs:
- irq = fail & irq_en.

## Timing
Reset values:
- tx_grant=0, tx_abort=0, irq=0, state=IDLE.
- retry_cnt=0, fail=0, coll_seen=0, idle counter=0.

Latency and sequencing:
- All outputs are registered. data_out is combinational from the registers.
- tx_grant rises on the clk after line_idle is first seen in WAIT_LINE.
- tx_abort and the tx_grant fall both occur on the clk after collision_detect is sampled.
- tx_req → WAIT_LINE takes 1 clk.

Boundary and simultaneous events:
- tx_done and collision_detect in the same cycle: tx_done wins, with no abort.
- A W1C write to fail in the same cycle the FSM sets fail: the set wins.
- max_retry=0: the first collision goes to FAIL.
- retry_cnt saturates at 15.
- A register write mid-operation is used at the next comparison; there is no restart.
- Reset mid-grant: tx_grant drops on the next clk and no tx_abort is issued.

## Configuration
- ECONET_BACKOFF_RANDOM_EN defined: backoff load uses the LFSR as described above.
- ECONET_BACKOFF_RANDOM_EN undefined: the LFSR is removed and load = mask + 1, giving a deterministic backoff of 2, 4, 8, … ticks.

## Structure
- Package econet_pkg holds:
  - the state enum (3-bit);
  - register bit-position constants;
  - the LFSR tap mask and seed 8'hA5.
- Sub-module econet_backoff_lfsr (clk, reset, q[7:0]) is instantiated only under ECONET_BACKOFF_RANDOM_EN.

## Test plan
- Idle grant: reset, then idle_thr=4, line_rx=1, tx_req=1 → tx_grant rises 1 clk after the 4th tick. tx_done → tx_grant=0, state=0.
- Busy line: idle_thr=4, line_rx toggles 0 every 3rd tick → tx_grant stays 0. Hold line_rx=1 → grant after 4 clean ticks.
- Collision: a collision during GRANTED → one tx_abort pulse, retry_cnt=1, coll_seen=1, state=3. Backoff is in 1..2 ticks, or exactly 2 ticks without the macro. The block then returns to WAIT_LINE.
- Give-up:
  - Set max_retry=2, irq_en=1, then apply 3 collisions → state=4, fail=1, irq=1.
  - Deassert tx_req → state=0. W1C bit 24 → irq=0.
- Priority and reset: tx_done together with collision_detect → no tx_abort, retry_cnt=0. Assert reset during GRANTED → all outputs 0 the next clk.
